// File: rtl/mnist_frame_sequencer.sv
// mnist_frame_sequencer
//   Feeds the LGN MNIST inference core. It holds one binary image as
//   FRAME_BYTES bytes in an internal buffer and streams the bytes to the
//   core's ui_in, one per clock. It then waits out the core pipeline
//   latency, captures the class index and offers it on a valid/ready port.
//
// Parameters
//   FRAME_BYTES  : bytes per frame / buffer depth (power of two, <= 256)
//   PIPE_LATENCY : cycles from the last byte on core_data to a valid core_index (>= 1)
//   RESTART_GAP  : idle cycles between result hand-off and auto restart
//
// Optional feature
//   `define MNIST_SEQ_AUTO_RESTART_EN : after each result hand-off, wait
//   RESTART_GAP idle cycles and then stream the buffer again without start.
//
// Ports
//   CLK, RST                    : clock (rising edge), async active-high reset
//   wr_en, wr_addr, wr_data     : buffer write port (dropped while a frame is streaming)
//   start                       : request one inference (level-sampled in IDLE)
//   busy                        : high in any state other than IDLE
//   core_data                   : registered byte to core ui_in
//   core_index                  : class index from core uio_out[3:0]
//   res_valid, res_ready, res_index : result hand-off
//   frame_count                 : completed frames, wraps 255 -> 0
module mnist_frame_sequencer #(
    parameter int FRAME_BYTES  = 32,
    parameter int PIPE_LATENCY = 4,
    parameter int RESTART_GAP  = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           wr_en,
    input  logic [$clog2(FRAME_BYTES)-1:0] wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic                           start,
    output logic                           busy,
    output logic [7:0]                     core_data,
    input  logic [3:0]                     core_index,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [3:0]                     res_index,
    output logic [7:0]                     frame_count
);

    localparam int AW = $clog2(FRAME_BYTES);
    localparam int KW = AW + 1;
    localparam int LW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

    state_t        state;
    logic [KW-1:0] byte_cnt;   // index of the next byte to load during STREAM
    logic [LW-1:0] lat_cnt;
    logic [7:0]    frame_buf [FRAME_BYTES];
    logic          go;         // IDLE -> STREAM on this edge
    logic          wr_ok;
    logic          handshake;

    assign handshake = (state == RESULT) && res_valid && res_ready;

`ifdef MNIST_SEQ_AUTO_RESTART_EN
    localparam int GW = (RESTART_GAP > 1) ? $clog2(RESTART_GAP) : 1;

    logic [GW-1:0] gap_cnt;
    logic          gap_arm;    // set by a hand-off, cleared when a frame starts

    assign go = (state == IDLE) &&
                (start || (gap_arm && gap_cnt == GW'(RESTART_GAP - 1)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gap_cnt <= '0;
            gap_arm <= 1'b0;
        end else if (handshake) begin
            gap_cnt <= '0;
            gap_arm <= 1'b1;
        end else if (go) begin
            gap_cnt <= '0;
            gap_arm <= 1'b0;
        end else if (gap_arm) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`else
    assign go = (state == IDLE) && start;
`endif

    // The frame in flight is frozen: writes are refused while streaming and
    // on the edge that launches a frame.
    assign wr_ok = (state == DRAIN) || (state == RESULT) || ((state == IDLE) && !go);

    // Buffer contents intentionally survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en && wr_ok)
            frame_buf[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            core_data   <= '0;
            res_valid   <= 1'b0;
            res_index   <= '0;
            frame_count <= '0;
            byte_cnt    <= '0;
            lat_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    core_data <= '0;
                    if (go) begin
                        // Byte 0 is loaded on the launch edge so it is on
                        // core_data in the first cycle after start.
                        state     <= STREAM;
                        busy      <= 1'b1;
                        core_data <= frame_buf[0];
                        byte_cnt  <= KW'(1);
                    end
                end
                STREAM: begin
                    if (byte_cnt == KW'(FRAME_BYTES)) begin
                        state     <= DRAIN;
                        core_data <= '0;
                        byte_cnt  <= '0;
                        lat_cnt   <= '0;
                    end else begin
                        core_data <= frame_buf[byte_cnt[AW-1:0]];
                        byte_cnt  <= byte_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == LW'(PIPE_LATENCY - 1)) begin
                        res_index <= core_index;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (handshake) begin
                        res_valid   <= 1'b0;
                        frame_count <= frame_count + 8'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// Scoreboard bench for mnist_frame_sequencer (default build, auto restart off).
// Stimulus pushes the expected frame bytes and result into queues; a monitor
// sampling on the falling edge pops them when a frame starts (busy rises)
// and when a result is handed off.
module tb_mnist_frame_sequencer;

    localparam int FB = 32;
    localparam int PL = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [3:0] core_index = '0;
    logic       res_ready = 1'b0;
    logic       busy, res_valid;
    logic [7:0] core_data, frame_count;
    logic [3:0] res_index;

    int checks = 0;
    int errors = 0;

    logic [FB*8-1:0] mdl;
    logic [FB*8-1:0] exp_frames[$];
    logic [11:0]     exp_res[$];   // {index, frame_count before hand-off}

    always #5 CLK = ~CLK;

    mnist_frame_sequencer #(.FRAME_BYTES(FB), .PIPE_LATENCY(PL), .RESTART_GAP(16)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .core_data(core_data), .core_index(core_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .frame_count(frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        mdl[a*8 +: 8] = d;
    endtask

    task automatic issue_frame(input logic [3:0] idx, input logic [7:0] fc);
        exp_frames.push_back(mdl);
        exp_res.push_back({idx, fc});
        core_index = idx;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!busy && !res_valid) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (res_valid) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Monitor
    logic            m_bq, m_vq;
    logic [3:0]      m_iq;
    int              m_pos;
    bit              m_act;
    logic [FB*8-1:0] m_cur;
    logic [11:0]     m_er;

    initial begin
        m_bq = 1'b0; m_vq = 1'b0; m_iq = '0; m_pos = 0; m_act = 1'b0; m_cur = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                m_bq = 1'b0; m_vq = 1'b0; m_act = 1'b0;
            end else begin
                if (busy && !m_bq) begin
                    if (exp_frames.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
                    else begin m_cur = exp_frames.pop_front(); m_act = 1'b1; m_pos = 0; end
                end
                if (m_act) begin
                    if (m_pos < FB)       chk("core_data", 32'(core_data), 32'(m_cur[m_pos*8 +: 8]));
                    else if (m_pos == FB) chk("core_data_zero", 32'(core_data), 32'd0);
                    if (m_pos < FB + PL) begin
                        chk("busy_in_frame", 32'(busy), 32'd1);
                        chk("res_valid_early", 32'(res_valid), 32'd0);
                    end else begin
                        chk("res_valid_latency", 32'(res_valid), 32'd1);
                        m_act = 1'b0;
                    end
                    m_pos++;
                end
                if (res_valid && m_vq) begin
                    chk("res_index_stable", 32'(res_index), 32'(m_iq));
                    chk("busy_in_result", 32'(busy), 32'd1);
                end
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                    else begin
                        m_er = exp_res.pop_front();
                        chk("res_index", 32'(res_index), 32'(m_er[11:8]));
                        chk("frame_count_pre", 32'(frame_count), 32'(m_er[7:0]));
                    end
                end
                m_bq = busy; m_vq = res_valid; m_iq = res_index;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        mdl = '0;
        RST = 1'b1;
        repeat (2) tick();
        chk("rst_core_data", 32'(core_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_index", 32'(res_index), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < FB; i++) wr(i, 8'(i));

        // A: basic frame, ready tied high
        res_ready = 1'b1;
        issue_frame(4'd7, 8'd0);
        wait_idle("idle_after_A");
        chk("fc_after_A", 32'(frame_count), 32'd1);

        // B: start held high, ready low; write during STREAM is dropped
        res_ready = 1'b0;
        exp_frames.push_back(mdl);
        exp_res.push_back({4'd3, 8'd1});
        core_index = 4'd3;
        start = 1'b1;
        tick();                       // cycle 1
        tick();                       // cycle 2
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        wait_valid("valid_B");
        core_index = 4'd9;            // must not disturb the captured index
        repeat (20) tick();
        wr(5, 8'hFF);                 // accepted in RESULT
        // C: launched by the still-held start once IDLE is reached
        exp_frames.push_back(mdl);
        exp_res.push_back({4'd9, 8'd2});
        res_ready = 1'b1;
        tick();                       // hand-off edge
        tick();                       // start sampled in IDLE
        start = 1'b0;
        wait_idle("idle_after_C");
        chk("fc_after_C", 32'(frame_count), 32'd3);

        // D: back-to-back writes, write dropped with start, write in DRAIN
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_en = 1'b0;
        mdl[2*8 +: 8] = 8'h22;
        exp_frames.push_back(mdl);
        exp_res.push_back({4'd12, 8'd3});
        core_index = 4'd12;
        start = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hAA;
        tick();                       // cycle 1
        start = 1'b0; wr_en = 1'b0;
        repeat (33) tick();           // cycle 34, DRAIN
        wr(0, 8'h5A);
        wait_idle("idle_after_D");
        chk("fc_after_D", 32'(frame_count), 32'd4);

        // E: reset in cycle 10 of STREAM aborts the frame
        exp_frames.push_back(mdl);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        RST = 1'b1;
        #1;
        chk("abort_core_data", 32'(core_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_frame_count", 32'(frame_count), 32'd0);
        tick();
        RST = 1'b0;
        tick();

        // F: buffer survived reset
        issue_frame(4'd1, 8'd0);
        wait_idle("idle_after_F");
        chk("fc_after_F", 32'(frame_count), 32'd1);

        // 255 more frames wrap frame_count to 0
        for (int f = 1; f < 256; f++) begin
            issue_frame(4'(f % 16), 8'(f));
            wait_idle("idle_wrap");
        end
        chk("fc_wrap", 32'(frame_count), 32'd0);

        tick();
        chk("frames_left", 32'(exp_frames.size()), 32'd0);
        chk("results_left", 32'(exp_res.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
